// File: rtl/matmul_sequencer.sv
// ---------------------------------------------------------------------------
// matmul_sequencer
//
// Control and storage wrapper around a combinational 3x3 multiply stage.
// The core loads operand matrices A and B through a register write port and
// pulses start. The sequencer steps the stage's result index 0..8, one
// element per cycle, and captures each result into a readable result file.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   wr_en    in   operand write strobe
//   wr_addr  in   [4:0]   0-8 A00..A22, 9-17 B00..B22 (row-major), 18-31 ignored
//   wr_data  in   [W-1:0] operand write data
//   start    in   single-cycle request to compute C = A x B
//   rd_addr  in   [3:0]   0-8 C00..C22 (row-major)
//   rd_data  out  [W-1:0] result[rd_addr], 0 for addresses 9-15
//   busy     out  computation in progress
//   done     out  one-cycle pulse when all nine results are valid
//   err      out  sticky: operand write attempted while busy
//
// Build option
//   MATMUL_PIPE_EN : register the stage output before capture; adds a DRAIN
//                    cycle (done 11 cycles after start instead of 10).
//
// State table
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start, index parked at 15 (stage outputs 0)
//   S_RUN   | index 0..8 drives the stage, one result captured per cycle
//   S_DRAIN | pipelined build only: capture the last registered result
//   S_DONE  | done pulse for one cycle, start accepted as in S_IDLE
// ---------------------------------------------------------------------------
module matmul_sequencer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [4:0]   wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic         start,
    input  logic [3:0]   rd_addr,
    output logic [W-1:0] rd_data,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [3:0] IDX_PARK = 4'd15;
    localparam logic [3:0] IDX_LAST = 4'd8;

    state_t       state;
    logic [3:0]   idx;

    logic [W-1:0] a_reg   [9];
    logic [W-1:0] b_reg   [9];
    logic [W-1:0] res_reg [9];

    logic [3:0]   row_base;
    logic [3:0]   col;
    logic [W-1:0] stage_out;
    logic         start_ok;

`ifdef MATMUL_PIPE_EN
    logic [W-1:0] stage_q;
    logic [3:0]   idx_q;
    logic         cap_v;
`endif

    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

    // Multiply stage: one element of C = A x B selected by idx, wrapping
    // modulo 2^W. Any index above 8 (the parked value) yields 0.
    always_comb begin
        row_base  = 4'd0;
        col       = 4'd0;
        stage_out = '0;
        if (idx < 4'd3) begin
            row_base = 4'd0;
        end else if (idx < 4'd6) begin
            row_base = 4'd3;
        end else begin
            row_base = 4'd6;
        end
        col = idx - row_base;
        if (idx <= IDX_LAST) begin
            stage_out = a_reg[row_base]        * b_reg[col]
                      + a_reg[row_base + 4'd1] * b_reg[col + 4'd3]
                      + a_reg[row_base + 4'd2] * b_reg[col + 4'd6];
        end
    end

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= IDX_PARK;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr_en && busy) begin
                err <= 1'b1;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state <= S_RUN;
                        idx   <= 4'd0;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                        idx   <= IDX_PARK;
                        busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (idx == IDX_LAST) begin
                        idx <= IDX_PARK;
`ifdef MATMUL_PIPE_EN
                        state <= S_DRAIN;
`else
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                    idx   <= IDX_PARK;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    idx   <= IDX_PARK;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand and result register files.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                a_reg[i]   <= '0;
                b_reg[i]   <= '0;
                res_reg[i] <= '0;
            end
`ifdef MATMUL_PIPE_EN
            stage_q <= '0;
            idx_q   <= IDX_PARK;
            cap_v   <= 1'b0;
`endif
        end else begin
            // Writes are locked out while a run is using the operands.
            if (wr_en && !busy) begin
                if (wr_addr < 5'd9) begin
                    a_reg[wr_addr[3:0]] <= wr_data;
                end else if (wr_addr < 5'd18) begin
                    b_reg[4'(wr_addr - 5'd9)] <= wr_data;
                end
            end
`ifdef MATMUL_PIPE_EN
            // The element presented in one cycle lands one cycle later.
            stage_q <= stage_out;
            idx_q   <= idx;
            cap_v   <= (state == S_RUN);
            if (cap_v) begin
                res_reg[idx_q] <= stage_q;
            end
`else
            if (state == S_RUN) begin
                res_reg[idx] <= stage_out;
            end
`endif
        end
    end

    assign rd_data = (rd_addr < 4'd9) ? res_reg[rd_addr] : '0;

endmodule

// File: tb/tb_matmul_sequencer.sv
`timescale 1ns/1ps
module tb_matmul_sequencer;

`ifdef MATMUL_PIPE_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 10;
`endif

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        wr_en   = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        start   = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    matmul_sequencer #(.W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Reference model: operand arrays, a run timer counted in cycles after the
    // accepted start, and the full product computed up front with plain math.
    logic [31:0] m_a    [9];
    logic [31:0] m_b    [9];
    logic [31:0] m_res  [9];
    logic [31:0] m_pend [9];
    bit          m_active;
    bit          m_busy;
    bit          m_done;
    bit          m_err;
    int          m_j;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) begin
            m_a[i]    = '0;
            m_b[i]    = '0;
            m_res[i]  = '0;
            m_pend[i] = '0;
        end
        m_active = 1'b0;
        m_busy   = 1'b0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        m_j      = 0;
    endtask

    task automatic model_step();
        bit was_busy;
        if (!rst_n) begin
            model_reset();
            return;
        end
        was_busy = m_busy;
        if (wr_en) begin
            if (was_busy) m_err = 1'b1;
            else if (int'(wr_addr) < 9)  m_a[int'(wr_addr)]     = wr_data;
            else if (int'(wr_addr) < 18) m_b[int'(wr_addr) - 9] = wr_data;
        end
        if (start && !was_busy) begin
            m_active = 1'b1;
            m_j      = -1;
            m_err    = 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    m_pend[r*3+c] = m_a[r*3]   * m_b[c]
                                  + m_a[r*3+1] * m_b[3+c]
                                  + m_a[r*3+2] * m_b[6+c];
        end
        m_busy = 1'b0;
        m_done = 1'b0;
        if (m_active) begin
            m_j++;
            m_busy = (m_j <= LAT - 2);
            m_done = (m_j == LAT - 1);
            if (m_done) begin
                m_res    = m_pend;
                m_active = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("err",  32'(err),  32'(m_err));
        if (!m_busy || rd_addr >= 4'd9)
            chk("rd_data", rd_data, (rd_addr < 4'd9) ? m_res[rd_addr] : 32'd0);
    end

    task automatic wr(input int addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = 5'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load(input logic [31:0] a [9], input logic [31:0] b [9]);
        for (int i = 0; i < 9; i++) wr(i, a[i]);
        for (int i = 0; i < 9; i++) wr(9 + i, b[i]);
    endtask

    task automatic finish_run(output int n);
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run(output int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_run(n);
    endtask

    task automatic rd_lit(input string nm, input int addr, input logic [31:0] exp);
        rd_addr = 4'(addr);
        #1;
        chk(nm, rd_data, exp);
        tick();
    endtask

    initial begin
        logic [31:0] a [9];
        logic [31:0] b [9];
        logic [31:0] exp_c [9];
        int n;
        int nd;

        model_reset();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err",  32'(err),  32'd0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) rd_lit("rst_rd", i, 32'd0);

        // Identity x 1..9
        a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        b = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        load(a, b);
        run(n);
        chk("id_latency", 32'(n), 32'(LAT));
        tick();
        chk("done_width", 32'(done), 32'd0);
        for (int i = 0; i < 9; i++) rd_lit("id_c", i, 32'(i + 1));

        // All ones; the last operand is written in the start cycle.
        a = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        b = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
        load(a, b);
        wr_en = 1'b1; wr_addr = 5'd17; wr_data = 32'd1; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        finish_run(n);
        chk("ones_latency", 32'(n), 32'(LAT));
        for (int i = 0; i < 9; i++) rd_lit("ones_c", i, 32'd3);

        // 1..9 x 9..1
        a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        b = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        exp_c = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
        load(a, b);
        run(n);
        for (int i = 0; i < 9; i++) rd_lit("seq_c", i, exp_c[i]);

        // Wrap modulo 2^32
        a = '{32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0};
        b = '{2, 0, 0, 0, 0, 0, 0, 0, 0};
        load(a, b);
        run(n);
        for (int i = 0; i < 9; i++) rd_lit("wrap_c", i, 32'd0);

        // Write while busy: operand untouched, err sticky until next start.
        a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        b = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        load(a, b);
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'd77;
        tick();
        wr_en = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        finish_run(n);
        chk("err_sticky", 32'(err), 32'd1);
        rd_lit("busy_wr_c11", 4, 32'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_clear", 32'(err), 32'd0);
        finish_run(n);
        rd_lit("a11_kept", 4, 32'd5);

        // Reset in cycle T+5 of a run
        rd_addr = 4'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (n < 5) begin
            if (n == 2) begin
                wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'd5;
            end
            tick();
            wr_en = 1'b0;
            n++;
        end
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_err",  32'(err),  32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_err",  32'(err),  32'd0);
        chk("arst_rd",   rd_data,   32'd0);
        for (int i = 0; i < 9; i++) rd_lit("arst_rd_all", i, 32'd0);
        rst_n = 1'b1;
        tick();
        a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        b = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        load(a, b);
        run(n);
        chk("post_rst_latency", 32'(n), 32'(LAT));
        for (int i = 0; i < 9; i++) rd_lit("post_rst_c", i, exp_c[i]);

        // start re-pulsed while busy, then start in the DONE cycle
        rd_addr = 4'd12;
        start = 1'b1;
        tick();
        start = 1'b0;
        nd = 0;
        for (int k = 1; k <= LAT + 4; k++) begin
            if (done === 1'b1) nd++;
            start = (k == 3);
            tick();
        end
        start = 1'b0;
        chk("single_done", 32'(nd), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_run(n);
        chk("run_a_latency", 32'(n), 32'(LAT));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", 32'(busy), 32'd1);
        finish_run(n);
        chk("restart_latency", 32'(n), 32'(LAT));
        chk("rd12_zero", rd_data, 32'd0);
        tick();

        // Randomized traffic, checked every cycle by the compare process.
        for (int k = 0; k < 600; k++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 5'($urandom_range(0, 23));
            wr_data = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 15));
            start   = ($urandom_range(0, 7) == 0);
            rd_addr = 4'($urandom_range(0, 15));
            tick();
        end
        wr_en = 1'b0;
        start = 1'b0;
        for (int k = 0; k < LAT + 2; k++) tick();
        for (int i = 0; i < 9; i++) begin
            rd_addr = 4'(i);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
